// File: rtl/scr1_ahb_pkg.sv
// Shared AHB-Lite definitions for the SCR1 two-master memory arbiter:
// bus width, HTRANS/HRESP encodings, pending-slot record and grant helper.
package scr1_ahb_pkg;

   localparam int SCR1_AHB_WIDTH = 32;

   localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

   localparam logic SCR1_HRESP_OKAY  = 1'b0;
   localparam logic SCR1_HRESP_ERROR = 1'b1;

   typedef struct packed {
      logic                      pend;
      logic [SCR1_AHB_WIDTH-1:0] addr;
      logic [2:0]                size;
      logic                      write;
   } type_scr1_ahb_arb_slot_s;

   typedef enum logic {
      MASTER_IMEM = 1'b0,
      MASTER_DMEM = 1'b1
   } type_scr1_ahb_master_e;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_IMEM = 2'd1,
      OWNER_DMEM = 2'd2
   } type_scr1_ahb_owner_e;

   function automatic logic scr1_ahb_is_active(input logic [1:0] htrans);
      return (htrans == SCR1_HTRANS_NONSEQ) || (htrans == SCR1_HTRANS_SEQ);
   endfunction

   // A tie goes to the master that did not win last time; fixed priority favours dmem.
   function automatic type_scr1_ahb_master_e scr1_ahb_arb_pick(
      input logic                  imem_pend,
      input logic                  dmem_pend,
      input type_scr1_ahb_master_e last_grant,
      input logic                  rr_en
   );
      if (imem_pend && dmem_pend) begin
         return (rr_en && (last_grant == MASTER_DMEM)) ? MASTER_IMEM : MASTER_DMEM;
      end
      if (dmem_pend) begin
         return MASTER_DMEM;
      end
      return MASTER_IMEM;
   endfunction

endpackage

// File: rtl/scr1_ahb_arb_slot.sv
// Per-master pending slot: holds one captured address phase until the
// arbiter hands it to the slave port.
module scr1_ahb_arb_slot
   import scr1_ahb_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      capture,
   input  logic                      clear,
   input  logic [SCR1_AHB_WIDTH-1:0] addr,
   input  logic [2:0]                size,
   input  logic                      write,
   output type_scr1_ahb_arb_slot_s   slot
);

   // A capture can only happen while the slot is empty, so it never races a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (capture) begin
         slot.pend  <= 1'b1;
         slot.addr  <= addr;
         slot.size  <= size;
         slot.write <= write;
      end else if (clear) begin
         slot.pend <= 1'b0;
      end
   end

endmodule

// File: rtl/scr1_ahb_mem_arbiter.sv
// Two-master (imem/dmem) to one-slave AHB-Lite arbiter with per-master
// pending slots, round-robin grant and pipelined slave address/data phases.
module scr1_ahb_mem_arbiter
   import scr1_ahb_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                imem_htrans,
   input  logic [SCR1_AHB_WIDTH-1:0] imem_haddr,
   input  logic [2:0]                imem_hsize,
   output logic                      imem_hready,
   output logic [SCR1_AHB_WIDTH-1:0] imem_hrdata,
   output logic                      imem_hresp,
   input  logic [1:0]                dmem_htrans,
   input  logic [SCR1_AHB_WIDTH-1:0] dmem_haddr,
   input  logic [2:0]                dmem_hsize,
   input  logic                      dmem_hwrite,
   input  logic [SCR1_AHB_WIDTH-1:0] dmem_hwdata,
   output logic                      dmem_hready,
   output logic [SCR1_AHB_WIDTH-1:0] dmem_hrdata,
   output logic                      dmem_hresp,
   output logic [1:0]                s_htrans,
   output logic [SCR1_AHB_WIDTH-1:0] s_haddr,
   output logic [2:0]                s_hsize,
   output logic                      s_hwrite,
   output logic [SCR1_AHB_WIDTH-1:0] s_hwdata,
   input  logic                      s_hready,
   input  logic [SCR1_AHB_WIDTH-1:0] s_hrdata,
   input  logic                      s_hresp
);

   type_scr1_ahb_arb_slot_s imem_slot;
   type_scr1_ahb_arb_slot_s dmem_slot;
   type_scr1_ahb_master_e   sel;
   type_scr1_ahb_master_e   last_grant;
   type_scr1_ahb_master_e   lock_master;
   type_scr1_ahb_owner_e    dph_owner;
   logic                    lock_valid;
   logic                    present;
   logic                    accept;
   logic                    imem_owner;
   logic                    dmem_owner;

   scr1_ahb_arb_slot u_imem_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .capture (scr1_ahb_is_active(imem_htrans) && imem_hready),
      .clear   (accept && (sel == MASTER_IMEM)),
      .addr    (imem_haddr),
      .size    (imem_hsize),
      .write   (1'b0),
      .slot    (imem_slot)
   );

   scr1_ahb_arb_slot u_dmem_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .capture (scr1_ahb_is_active(dmem_htrans) && dmem_hready),
      .clear   (accept && (sel == MASTER_DMEM)),
      .addr    (dmem_haddr),
      .size    (dmem_hsize),
      .write   (dmem_hwrite),
      .slot    (dmem_slot)
   );

   // A presented-but-stalled address keeps its winner so the slave never sees it change.
   always_comb begin
      sel      = lock_valid ? lock_master
                            : scr1_ahb_arb_pick(imem_slot.pend, dmem_slot.pend, last_grant, RR_EN);
      present  = lock_valid || imem_slot.pend || dmem_slot.pend;
      s_htrans = SCR1_HTRANS_IDLE;
      s_haddr  = '0;
      s_hsize  = '0;
      s_hwrite = 1'b0;
      if (present) begin
         s_htrans = SCR1_HTRANS_NONSEQ;
         if (sel == MASTER_DMEM) begin
            s_haddr  = dmem_slot.addr;
            s_hsize  = dmem_slot.size;
            s_hwrite = dmem_slot.write;
         end else begin
            s_haddr  = imem_slot.addr;
            s_hsize  = imem_slot.size;
            s_hwrite = imem_slot.write;
         end
      end
   end

   assign accept = present && s_hready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_valid  <= 1'b0;
         lock_master <= MASTER_IMEM;
         last_grant  <= MASTER_IMEM;
         dph_owner   <= OWNER_NONE;
      end else if (s_hready) begin
         lock_valid <= 1'b0;
         if (accept) begin
            last_grant <= sel;
            dph_owner  <= (sel == MASTER_DMEM) ? OWNER_DMEM : OWNER_IMEM;
         end else begin
            dph_owner  <= OWNER_NONE;
         end
      end else if (present) begin
         lock_valid  <= 1'b1;
         lock_master <= sel;
      end
   end

   // Only the data-phase owner sees the slave response; the other master stalls on its own slot.
   assign imem_owner  = (dph_owner == OWNER_IMEM);
   assign dmem_owner  = (dph_owner == OWNER_DMEM);

   assign imem_hready = imem_owner ? s_hready : !imem_slot.pend;
   assign imem_hrdata = imem_owner ? s_hrdata : '0;
   assign imem_hresp  = imem_owner ? s_hresp  : SCR1_HRESP_OKAY;

   assign dmem_hready = dmem_owner ? s_hready : !dmem_slot.pend;
   assign dmem_hrdata = dmem_owner ? s_hrdata : '0;
   assign dmem_hresp  = dmem_owner ? s_hresp  : SCR1_HRESP_OKAY;

   assign s_hwdata    = dmem_owner ? dmem_hwdata : '0;

endmodule
